// File: rtl/cmd_rx_pkg.sv
// cmd_rx_pkg: shared definitions for the SD CMD-line receiver.
//   - rxState_t   : receiver FSM state encoding
//   - RESP_BITS   : length of an SD short response frame (48)
//   - PAYLOAD_BITS: command index plus argument (38)
//   - CRC_BITS    : CRC7 width (7)
//   - CRC7_POLY   : x^7 + x^3 + 1, leading term dropped (7'h09)
package cmd_rx_pkg;

  localparam int RESP_BITS    = 48;
  localparam int PAYLOAD_BITS = 38;
  localparam int CRC_BITS     = 7;

  localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    RECEIVE    = 3'd2,
    DONE       = 3'd3,
    NO_RESP    = 3'd4
  } rxState_t;

endpackage

// File: rtl/crc7_serial.sv
// crc7_serial: bit-serial CRC7 (x^7 + x^3 + 1, initial value 0), one bit per
// rising edge of iClock_SD. Shared by the STP receive and PTS transmit paths.
// Ports:
//   iClock_SD : SD clock
//   iReset    : synchronous active-low reset
//   iClear    : synchronous clear back to 0 (wins over iShift)
//   iShift    : feed iBit into the CRC on this edge
//   iBit      : serial data bit, MSB of the frame first
//   oCrc      : current CRC7 remainder
module crc7_serial
  import cmd_rx_pkg::*;
(
  input  logic                iClock_SD,
  input  logic                iReset,
  input  logic                iClear,
  input  logic                iShift,
  input  logic                iBit,
  output logic [CRC_BITS-1:0] oCrc
);

  logic feedback;
  assign feedback = iBit ^ oCrc[CRC_BITS-1];

  always_ff @(posedge iClock_SD) begin
    if (!iReset || iClear) begin
      oCrc <= '0;
    end else if (iShift) begin
      oCrc <= {oCrc[CRC_BITS-2:0], 1'b0} ^ (feedback ? CRC7_POLY : '0);
    end
  end

endmodule

// File: rtl/cmd_stp_receiver.sv
// cmd_stp_receiver: serial-to-parallel receiver for the SD CMD line.
// Frames a 48-bit response (start, transmission, 6-bit index, 32-bit
// argument, CRC7, end), checks framing and CRC7, and presents the 38-bit
// payload to the physical block controller.
// Optional feature: define CMD_RX_CRC7_EN to build the CRC7 checker; without
// it oCrc_error is tied to 0 and the CRC field is shifted in but ignored.
// Ports:
//   iClock_SD           : SD clock, all logic on the rising edge
//   iReset              : synchronous active-low reset
//   iReset_wrapper      : synchronous active-high soft clear (same as reset)
//   iEnable             : receive enable level
//   iCmd_in             : CMD line sample (idles high)
//   oPad_response       : {cmd_index, argument} = frame bits [45:8]
//   oReception_complete : a full-length frame was received
//   oNo_response        : no start bit within TIMEOUT high samples
//   oFrame_error        : transmission bit != 0 or end bit != 1
//   oCrc_error          : received CRC7 differs from the computed one
//   oBusy               : waiting for or receiving a frame
//   oState              : debug view of the FSM state register
// Handshake: there is no valid/ready pair; iEnable is a level. Results are
// held for as long as iEnable stays high and cleared one edge after it falls,
// so the controller must drop iEnable for at least one edge to re-arm.
module cmd_stp_receiver
  import cmd_rx_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                    iClock_SD,
  input  logic                    iReset,
  input  logic                    iReset_wrapper,
  input  logic                    iEnable,
  input  logic                    iCmd_in,
  output logic [PAYLOAD_BITS-1:0] oPad_response,
  output logic                    oReception_complete,
  output logic                    oNo_response,
  output logic                    oFrame_error,
  output logic                    oCrc_error,
  output logic                    oBusy,
  output rxState_t                oState
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last bit counter value whose sample still belongs to the CRC range
  // (frame bit 8 is sampled with the counter at 39).
  localparam logic [5:0] LAST_CRC_CNT = 6'(RESP_BITS - 9);
  localparam logic [5:0] LAST_CNT     = 6'(RESP_BITS - 1);

  rxState_t               state;
  logic [CNT_W-1:0]       timeoutCnt;
  logic [5:0]             bitCnt;
  logic [RESP_BITS-1:0]   shiftReg;
  logic                   softReset;
  logic                   crcErrNext;

  assign softReset = !iReset || iReset_wrapper;
  assign oBusy     = (state == WAIT_START) || (state == RECEIVE);
  assign oState    = state;

`ifdef CMD_RX_CRC7_EN
  logic [CRC_BITS-1:0] crc;
  logic                crcClear;
  logic                crcShift;

  // Held at zero until the start bit, which is itself the first CRC bit.
  assign crcClear = iReset_wrapper || (state == IDLE) ||
                    ((state == WAIT_START) && iCmd_in);
  assign crcShift = iEnable &&
                    (((state == WAIT_START) && !iCmd_in) ||
                     ((state == RECEIVE) && (bitCnt <= LAST_CRC_CNT)));

  crc7_serial uCrc7 (
    .iClock_SD (iClock_SD),
    .iReset    (iReset),
    .iClear    (crcClear),
    .iShift    (crcShift),
    .iBit      (iCmd_in),
    .oCrc      (crc)
  );

  assign crcErrNext = (shiftReg[7:1] != crc);
`else
  logic unusedCrcField;
  assign unusedCrcField = ^shiftReg[7:1];
  assign crcErrNext     = 1'b0;
`endif

  always_ff @(posedge iClock_SD) begin
    if (softReset) begin
      state               <= IDLE;
      timeoutCnt          <= '0;
      bitCnt              <= '0;
      shiftReg            <= '0;
      oPad_response       <= '0;
      oReception_complete <= 1'b0;
      oNo_response        <= 1'b0;
      oFrame_error        <= 1'b0;
      oCrc_error          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeoutCnt <= '0;
          bitCnt     <= '0;
          if (iEnable) state <= WAIT_START;
        end
        WAIT_START: begin
          if (!iEnable) begin
            state <= IDLE;
          end else if (!iCmd_in) begin
            // Start bit is accepted even on the edge the timeout would fire.
            state    <= RECEIVE;
            bitCnt   <= 6'd1;
            shiftReg <= {shiftReg[RESP_BITS-2:0], iCmd_in};
          end else if (timeoutCnt == CNT_W'(TIMEOUT)) begin
            state        <= NO_RESP;
            oNo_response <= 1'b1;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        RECEIVE: begin
          if (!iEnable) begin
            state <= IDLE;
          end else begin
            shiftReg <= {shiftReg[RESP_BITS-2:0], iCmd_in};
            if (bitCnt == LAST_CNT) state <= DONE;
            else                    bitCnt <= bitCnt + 1'b1;
          end
        end
        DONE: begin
          if (!iEnable) begin
            state               <= IDLE;
            oPad_response       <= '0;
            oReception_complete <= 1'b0;
            oFrame_error        <= 1'b0;
            oCrc_error          <= 1'b0;
          end else begin
            oReception_complete <= 1'b1;
            oPad_response       <= shiftReg[45:8];
            oFrame_error        <= shiftReg[46] || !shiftReg[0];
            oCrc_error          <= crcErrNext;
          end
        end
        NO_RESP: begin
          if (!iEnable) begin
            state        <= IDLE;
            oNo_response <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_stp_receiver.sv
// tb_cmd_stp_receiver: self-checking bench for cmd_stp_receiver.
// Frames are built from (index, argument) with a CRC7 obtained by polynomial
// long division, and expected results are derived from the frame fields.
module tb_cmd_stp_receiver;
  import cmd_rx_pkg::*;

  localparam int TIMEOUT = 64;

  logic        iClock_SD = 1'b0;
  logic        iReset = 1'b0;
  logic        iReset_wrapper = 1'b0;
  logic        iEnable = 1'b0;
  logic        iCmd_in = 1'b1;
  logic [37:0] oPad_response;
  logic        oReception_complete;
  logic        oNo_response;
  logic        oFrame_error;
  logic        oCrc_error;
  logic        oBusy;
  rxState_t    oState;

  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] exp_q[$];

  cmd_stp_receiver #(.TIMEOUT(TIMEOUT)) dut (
    .iClock_SD           (iClock_SD),
    .iReset              (iReset),
    .iReset_wrapper      (iReset_wrapper),
    .iEnable             (iEnable),
    .iCmd_in             (iCmd_in),
    .oPad_response       (oPad_response),
    .oReception_complete (oReception_complete),
    .oNo_response        (oNo_response),
    .oFrame_error        (oFrame_error),
    .oCrc_error          (oCrc_error),
    .oBusy               (oBusy),
    .oState              (oState)
  );

  // clock / reset
  always #5 iClock_SD = ~iClock_SD;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs set before the call are sampled on it, outputs
  // are observed 1 time unit after it.
  task automatic step();
    @(posedge iClock_SD);
    #1;
  endtask

  // CRC7 of a 40-bit message by long division of msg * x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [39:0] msg);
    logic [46:0] m;
    m = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b00, idx, arg};
    return {head, crc_ref(head), 1'b1};
  endfunction

  // driver: enable, `gap` idle-high samples, then the first n bits of f
  task automatic drive_bits(input logic [47:0] f, input int gap, input int n);
    iEnable = 1'b1;
    iCmd_in = 1'b1;
    step();
    for (int i = 0; i < gap; i++) step();
    for (int i = 47; i > 47 - n; i--) begin
      iCmd_in = f[i];
      step();
    end
    iCmd_in = 1'b1;
  endtask

  // Full frame then the result check one edge after the end bit.
  task automatic run_frame(input string tag, input logic [47:0] f, input int gap);
    logic [37:0] exp_pay;
    logic        exp_ferr, exp_cerr;
    exp_q.push_back(f[45:8]);
    exp_ferr = f[46] | ~f[0];
`ifdef CMD_RX_CRC7_EN
    exp_cerr = (f[7:1] != crc_ref(f[47:8]));
`else
    exp_cerr = 1'b0;
`endif
    drive_bits(f, gap, 20);
    check({tag, "_busy_mid"}, 64'(oBusy), 64'd1);
    for (int i = 27; i >= 0; i--) begin
      iCmd_in = f[i];
      step();
    end
    iCmd_in = 1'b1;
    check({tag, "_early"}, 64'(oReception_complete), 64'd0);
    step();
    exp_pay = exp_q.pop_front();
    check({tag, "_done"}, 64'(oReception_complete), 64'd1);
    check({tag, "_payload"}, 64'(oPad_response), 64'(exp_pay));
    check({tag, "_ferr"}, 64'(oFrame_error), 64'(exp_ferr));
    check({tag, "_cerr"}, 64'(oCrc_error), 64'(exp_cerr));
    check({tag, "_noresp"}, 64'(oNo_response), 64'd0);
    step();
    check({tag, "_hold"}, 64'(oReception_complete), 64'd1);
    iEnable = 1'b0;
    step();
    check({tag, "_clear"}, 64'(oReception_complete), 64'd0);
  endtask

  initial begin
    logic [47:0] f;
    logic        seen;
    int          kind;

    iReset = 1'b0;
    step();
    step();
    check("rst_state", 64'(oState), 64'(IDLE));
    check("rst_pad", 64'(oPad_response), 64'd0);
    check("rst_flags", 64'({oReception_complete, oNo_response, oFrame_error, oCrc_error, oBusy}), 64'd0);
    iReset = 1'b1;
    step();

    // CMD17 R1, start bit 10 cycles after enable
    run_frame("cmd17", mk_frame(6'd17, 32'h0000_0900), 9);

    // timeout with CMD constantly high
    iEnable = 1'b1;
    iCmd_in = 1'b1;
    step();                                   // edge E
    for (int i = 0; i < TIMEOUT; i++) step(); // E+1 .. E+64
    check("to_not_yet", 64'(oNo_response), 64'd0);
    step();                                   // E+65
    check("to_flag", 64'(oNo_response), 64'd1);
    check("to_nocomp", 64'(oReception_complete), 64'd0);
    check("to_busy", 64'(oBusy), 64'd0);
    step();
    check("to_hold", 64'(oNo_response), 64'd1);
    iEnable = 1'b0;
    step();
    check("to_clear", 64'(oNo_response), 64'd0);

    // start bit on exactly the 64th sample
    f = mk_frame(6'd3, 32'hABCD_1234);
    iEnable = 1'b1;
    iCmd_in = 1'b1;
    step();
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step();
      seen |= oNo_response;
    end
    for (int i = 47; i >= 0; i--) begin
      iCmd_in = f[i];
      step();
      seen |= oNo_response;
    end
    iCmd_in = 1'b1;
    step();
    check("late_noresp", 64'(seen | oNo_response), 64'd0);
    check("late_done", 64'(oReception_complete), 64'd1);
    check("late_payload", 64'(oPad_response), 64'({6'd3, 32'hABCD_1234}));
    iEnable = 1'b0;
    step();

    // CRC bit flipped, end bit forced low
    f = mk_frame(6'd17, 32'h0000_0900);
    f[4] = ~f[4];
    run_frame("crcflip", f, 2);
    f = mk_frame(6'd17, 32'h0000_0900);
    f[0] = 1'b0;
    run_frame("endbit", f, 2);

    // abort at bit 20, re-enable, valid frame
    drive_bits(mk_frame(6'd8, 32'h1234_5678), 4, 20);
    iEnable = 1'b0;
    step();
    check("abort_busy", 64'(oBusy), 64'd0);
    check("abort_state", 64'(oState), 64'(IDLE));
    for (int i = 0; i < 30; i++) step();
    check("abort_noflag", 64'({oReception_complete, oNo_response}), 64'd0);
    run_frame("rearm", mk_frame(6'd8, 32'h1234_5678), 5);

    // soft clear mid-frame
    drive_bits(mk_frame(6'd55, 32'hFFFF_0000), 3, 25);
    iReset_wrapper = 1'b1;
    step();
    iReset_wrapper = 1'b0;
    iEnable = 1'b0;
    check("wrst_state", 64'(oState), 64'(IDLE));
    check("wrst_out", 64'({oPad_response, oReception_complete, oNo_response, oFrame_error, oCrc_error, oBusy}), 64'd0);
    step();

    // hard reset while in DONE
    drive_bits(mk_frame(6'd2, 32'hDEAD_BEEF), 1, 48);
    step();
    check("hrst_pre", 64'(oReception_complete), 64'd1);
    iReset = 1'b0;
    step();
    check("hrst_state", 64'(oState), 64'(IDLE));
    check("hrst_out", 64'({oPad_response, oReception_complete, oNo_response, oFrame_error, oCrc_error, oBusy}), 64'd0);
    iReset = 1'b1;
    iEnable = 1'b0;
    step();

    // random frames with random corruption
    for (int n = 0; n < 10; n++) begin
      f = mk_frame(6'($urandom_range(0, 63)), 32'($urandom()));
      kind = $urandom_range(0, 3);
      case (kind)
        1: f[$urandom_range(1, 7)] ^= 1'b1;
        2: f[0] = 1'b0;
        3: f[46] = 1'b1;
        default: ;
      endcase
      run_frame($sformatf("rnd%0d", n), f, $urandom_range(0, TIMEOUT - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
